// File: rtl/subtractor_4b_pkg.sv
// Shared constants for the 4-bit subtractor slice of the datapath.
package subtractor_4b_pkg;

    // Operand/result width the subtractor is built and verified at.
    localparam int unsigned SUB_WIDTH = 4;

endpackage : subtractor_4b_pkg

// File: rtl/subtractor_4b_full_subtractor.sv
// One-bit full subtractor: d = a - b - bin, with bout signalling a borrow
// out of this bit position into the next more significant stage.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    // Difference bit and borrow-out of a single ripple stage.
    always_comb begin
        d    = a ^ b ^ bin;
        bout = (~a & b) | (~(a ^ b) & bin);
    end

endmodule : full_subtractor

// File: rtl/subtractor_4b.sv
// 4-bit subtractor: out = num1 - num2 (mod 2^WIDTH), built from a
// ripple-borrow chain of full subtractors. The difference and its
// borrow/overflow flags are combinational; a registered copy with a
// synchronous reset feeds clocked consumers one cycle later.
// Port order keeps out, num1, num2 first so legacy 3-port positional
// instances remain valid.
module subtractor_4b
    import subtractor_4b_pkg::*;
#(
    parameter int unsigned WIDTH = SUB_WIDTH
) (
    output logic [WIDTH-1:0] out,
    input  logic [WIDTH-1:0] num1,
    input  logic [WIDTH-1:0] num2,
    input  logic             clk,
    input  logic             rst,
    output logic             borrow,
    output logic             overflow,
    output logic [WIDTH-1:0] diff_q,
    output logic             borrow_q,
    output logic             ovf_q
);

    // Borrow chain: entry i is the borrow into stage i; the LSB has none.
    logic [WIDTH:0]   borrowChain;
    logic [WIDTH-1:0] diffBits;

    // Next-state values for the output register stage.
    logic [WIDTH-1:0] diff_d;
    logic             borrow_d;
    logic             ovf_d;

    assign borrowChain[0] = 1'b0;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_stage
            full_subtractor u_fs (
                .a    (num1[gi]),
                .b    (num2[gi]),
                .bin  (borrowChain[gi]),
                .d    (diffBits[gi]),
                .bout (borrowChain[gi+1])
            );
        end
    endgenerate

    // Live result and flags; signed overflow happens only when the operand
    // signs differ and the result sign disagrees with the minuend.
    always_comb begin
        out      = diffBits;
        borrow   = borrowChain[WIDTH];
        overflow = (num1[WIDTH-1] != num2[WIDTH-1]) &&
                   (diffBits[WIDTH-1] != num1[WIDTH-1]);
        diff_d   = diffBits;
        borrow_d = borrowChain[WIDTH];
        ovf_d    = overflow;
    end

    // Output register stage: reset wins over capture of the live result.
    always_ff @(posedge clk) begin
        if (rst) begin
            diff_q   <= '0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            ovf_q    <= ovf_d;
        end
    end

endmodule : subtractor_4b

// File: tb/tb_subtractor_4b.sv
// Self-checking bench for subtractor_4b: expected combinational and
// registered results are queued when stimulus is driven and popped when
// the corresponding DUT output is sampled.
module tb_subtractor_4b;

    typedef struct {
        logic [3:0] d;
        logic       b;
        logic       v;
    } expT;

    logic       clk;
    logic       rst;
    logic [3:0] num1;
    logic [3:0] num2;
    logic [3:0] out;
    logic       borrow;
    logic       overflow;
    logic [3:0] diff_q;
    logic       borrow_q;
    logic       ovf_q;

    expT combQ[$];
    expT regQ[$];

    int checks   = 0;
    int failures = 0;

    subtractor_4b #(.WIDTH(4)) dut (
        .out      (out),
        .num1     (num1),
        .num2     (num2),
        .clk      (clk),
        .rst      (rst),
        .borrow   (borrow),
        .overflow (overflow),
        .diff_q   (diff_q),
        .borrow_q (borrow_q),
        .ovf_q    (ovf_q)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural reference using integer arithmetic and signed range test.
    function automatic expT model(input int a, input int b);
        expT r;
        int  sa;
        int  sb;
        int  sdiff;
        sa    = (a > 7) ? a - 16 : a;
        sb    = (b > 7) ? b - 16 : b;
        sdiff = sa - sb;
        r.d   = 4'((a - b) & 15);
        r.b   = (a < b);
        r.v   = (sdiff > 7) || (sdiff < -8);
        return r;
    endfunction

    // Single comparison point; counts every evaluation and every failure.
    task automatic checkVal(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive operands and queue the expected live and registered results.
    task automatic applyStimulus(input int a, input int b);
        expT e;
        num1 = 4'(a);
        num2 = 4'(b);
        e = model(a, b);
        combQ.push_back(e);
        if (rst) begin
            e.d = 4'd0;
            e.b = 1'b0;
            e.v = 1'b0;
        end
        regQ.push_back(e);
    endtask

    // Pop and compare either the combinational or registered expectation.
    task automatic checkOutput(input string tag, input bit registered);
        expT e;
        if (registered ? (regQ.size() == 0) : (combQ.size() == 0)) begin
            checks++;
            failures++;
            $display("[TB] FAIL %s: observed empty scoreboard expected entry", tag);
            return;
        end
        if (registered) begin
            e = regQ.pop_front();
            checkVal({tag, ".diff_q"},   diff_q,           e.d);
            checkVal({tag, ".borrow_q"}, {3'b0, borrow_q}, {3'b0, e.b});
            checkVal({tag, ".ovf_q"},    {3'b0, ovf_q},    {3'b0, e.v});
        end else begin
            e = combQ.pop_front();
            checkVal({tag, ".out"},      out,              e.d);
            checkVal({tag, ".borrow"},   {3'b0, borrow},   {3'b0, e.b});
            checkVal({tag, ".overflow"}, {3'b0, overflow}, {3'b0, e.v});
        end
    endtask

    // One clock of stimulus: drive at the falling edge, check the live
    // result 1 ns later, then check the register just after the rising edge.
    task automatic doStep(input int a, input int b, input string tag);
        @(negedge clk);
        applyStimulus(a, b);
        #1;
        checkOutput(tag, 1'b0);
        @(posedge clk);
        #1;
        checkOutput(tag, 1'b1);
    endtask

    // Directed sequence followed by the exhaustive sweep.
    initial begin
        int pairs[9][2] = '{'{4, 2}, '{6, 3}, '{15, 4}, '{14, 2}, '{7, 5},
                            '{1, 11}, '{5, 14}, '{8, 1}, '{7, 15}};
        rst  = 1'b1;
        num1 = 4'd0;
        num2 = 4'd0;

        doStep(0, 0, "reset_zero");
        doStep(9, 9, "reset_hold");

        rst = 1'b0;
        foreach (pairs[i]) begin
            doStep(pairs[i][0], pairs[i][1], $sformatf("dir_%0d_%0d", pairs[i][0], pairs[i][1]));
        end

        doStep(6, 3, "reg_6_3");

        rst = 1'b1;
        doStep(5, 14, "midreset");
        checkVal("midreset.live_out", out, 4'd7);
        checkVal("midreset.diff_q",   diff_q, 4'd0);

        rst = 1'b0;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                doStep(a, b, $sformatf("ex_%0d_%0d", a, b));
            end
        end

        if (combQ.size() != 0 || regQ.size() != 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL scoreboard_drain: observed %0d left expected 0", combQ.size() + regQ.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule : tb_subtractor_4b
